// File: rtl/param_memory_pkg.sv
// Shared types and constants for the parametrised data memory.
// Holds the controller state encoding, request op encoding and latency bounds.
package param_memory_pkg;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_READ,
        OP_WRITE,
        OP_ILLEGAL
    } op_t;

    function automatic op_t decode_op(input logic rd, input logic wr);
        if (rd && !wr) return OP_READ;
        if (!rd && wr) return OP_WRITE;
        return OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/param_memory_mem_array.sv
// Storage array: one synchronous write port and one registered read port.
// No reset; contents are initialised by the owner's clear sweep.
module mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
        rdata <= r_mem[raddr];
    end

endmodule

// File: rtl/param_memory.sv
// Handshaked single-port RAM: en/ready request protocol, programmable access
// latency, and a post-reset sweep that fills every word with INIT_VALUE.
//
// state    | meaning
// CLEAR    | sweeping INIT_VALUE into every word after reset
// IDLE     | waiting for en
// BUSY     | request captured, counting down latency
// DONE     | access complete, ready high until en drops
module param_memory
    import param_memory_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 7,
    parameter int                LATENCY    = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] input_data,
    output logic [DATA_W-1:0] output_data,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    generate
        if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
            $error("param_memory: LATENCY out of range 1..15");
        end
    endgenerate

    state_t            r_state, w_next;
    op_t               r_op;
    logic [ADDR_W-1:0] r_clr_addr, r_addr;
    logic [DATA_W-1:0] r_data, r_out;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    logic              w_accept, w_fire, w_clr_we, w_we;
    logic [ADDR_W-1:0] w_waddr, w_raddr;
    logic [DATA_W-1:0] w_wdata, w_rdata;

    assign w_accept = (r_state == ST_IDLE) && en;
    assign w_fire   = (r_state == ST_BUSY) && (r_cnt == '0);
    assign w_clr_we = (r_state == ST_CLEAR);

    // Reset edge suppresses both the sweep write and any pending request write.
    assign w_we    = !rst && (w_clr_we || (w_fire && r_op == OP_WRITE));
    assign w_waddr = w_clr_we ? r_clr_addr : r_addr;
    assign w_wdata = w_clr_we ? INIT_VALUE : r_data;
    // Read port looks at the live address in IDLE so LATENCY=1 reads are ready in time.
    assign w_raddr = (r_state == ST_IDLE) ? address : r_addr;

    mem_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk  (clk),
        .we   (w_we),
        .waddr(w_waddr),
        .wdata(w_wdata),
        .raddr(w_raddr),
        .rdata(w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_CLEAR;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_addr == {ADDR_W{1'b1}}) w_next = ST_IDLE;
            ST_IDLE:  if (en) w_next = ST_BUSY;
            ST_BUSY:  if (r_cnt == '0) w_next = ST_DONE;
            ST_DONE:  if (!en) w_next = ST_IDLE;
            default:  w_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_addr <= '0;
            r_cnt      <= '0;
            r_out      <= '0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_op       <= OP_READ;
        end else begin
            if (w_clr_we) r_clr_addr <= r_clr_addr + ADDR_W'(1);
            if (w_accept) begin
                r_addr <= address;
                r_data <= input_data;
                r_op   <= decode_op(read, write);
                r_cnt  <= CNT_W'(LATENCY - 1);
            end
            if (r_state == ST_BUSY && r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
            if (w_fire) begin
                if (r_op == OP_READ)    r_out <= w_rdata;
                if (r_op == OP_ILLEGAL) r_err <= 1'b1;
            end
            if (r_state == ST_DONE && !en) r_err <= 1'b0;
        end
    end

    assign output_data = r_out;
    assign err         = r_err;
    assign ready       = (r_state == ST_DONE);
    assign busy        = (r_state == ST_CLEAR) || (r_state == ST_BUSY);

endmodule

// File: tb/tb_param_memory.sv
// Directed bench for param_memory: a default instance (8b x 128, LATENCY=1)
// and a 16b x 16, LATENCY=4 instance driven from one vector table.
module tb_param_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, en0, rd0, wr0, rdy0, err0, busy0;
    logic [6:0]  a0;
    logic [7:0]  d0, q0;
    logic        rst1, en1, rd1, wr1, rdy1, err1, busy1;
    logic [3:0]  a1;
    logic [15:0] d1, q1;

    int checks = 0;
    int errors = 0;

    param_memory dut0 (
        .clk(clk), .rst(rst0), .en(en0), .read(rd0), .write(wr0),
        .address(a0), .input_data(d0), .output_data(q0),
        .ready(rdy0), .err(err0), .busy(busy0)
    );

    param_memory #(.DATA_W(16), .ADDR_W(4), .LATENCY(4)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .read(rd1), .write(wr1),
        .address(a1), .input_data(d1), .output_data(q1),
        .ready(rdy1), .err(err1), .busy(busy1)
    );

    typedef struct {
        int          which;
        logic        rd;
        logic        wr;
        logic [6:0]  addr;
        logic [15:0] din;
        int          hold;
        int          lat;
        logic        err;
        logic [15:0] q;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int which, input logic e, input logic rd, input logic wr,
                          input logic [6:0] a, input logic [15:0] d);
        if (which == 0) begin
            en0 = e; rd0 = rd; wr0 = wr; a0 = a; d0 = d[7:0];
        end else begin
            en1 = e; rd1 = rd; wr1 = wr; a1 = a[3:0]; d1 = d;
        end
    endtask

    function automatic logic get_rdy(input int which);
        return (which == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic get_err(input int which);
        return (which == 0) ? err0 : err1;
    endfunction

    function automatic logic get_busy(input int which);
        return (which == 0) ? busy0 : busy1;
    endfunction

    function automatic logic [15:0] get_q(input int which);
        return (which == 0) ? {8'h00, q0} : q1;
    endfunction

    task automatic wait_clear(input int which, input int exp_len, input string name);
        int   n;
        logic saw_rdy;
        n = 0;
        saw_rdy = 1'b0;
        do begin
            tick();
            n++;
            if (get_rdy(which)) saw_rdy = 1'b1;
        end while (get_busy(which) && n < 1000);
        chk({name, "_len"}, n, exp_len);
        chk({name, "_rdy"}, saw_rdy, 1'b0);
    endtask

    // Full handshake; during any hold phase the inputs are scrambled to prove
    // they neither re-trigger nor alter the finished access.
    task automatic do_req(input int which, input logic rd, input logic wr,
                          input logic [6:0] a, input logic [15:0] d, input int hold,
                          input int exp_lat, input logic exp_err, input logic [15:0] exp_q,
                          input string name);
        int   lat;
        logic stay;
        set_in(which, 1'b1, rd, wr, a, d);
        tick();
        lat = 0;
        while (!get_rdy(which) && lat < 40) begin
            tick();
            lat++;
        end
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_err"}, get_err(which), exp_err);
        chk({name, "_q"}, get_q(which), exp_q);
        if (hold > 0) begin
            stay = 1'b1;
            for (int k = 0; k < hold; k++) begin
                set_in(which, 1'b1, rd, wr, a ^ 7'd1, ~d);
                tick();
                if (!get_rdy(which)) stay = 1'b0;
            end
            chk({name, "_hold_rdy"}, stay, 1'b1);
            chk({name, "_hold_q"}, get_q(which), exp_q);
        end
        set_in(which, 1'b0, 1'b0, 1'b0, a, d);
        tick();
        chk({name, "_exit_rdy"}, get_rdy(which), 1'b0);
        chk({name, "_exit_err"}, get_err(which), 1'b0);
    endtask

    initial begin
        logic saw;
        int   lat;

        vecs[0]  = '{0, 1'b1, 1'b0, 7'd0,   16'h0000, 0, 1, 1'b0, 16'h0000};
        vecs[1]  = '{0, 1'b1, 1'b0, 7'd64,  16'h0000, 0, 1, 1'b0, 16'h0000};
        vecs[2]  = '{0, 1'b1, 1'b0, 7'd127, 16'h0000, 0, 1, 1'b0, 16'h0000};
        vecs[3]  = '{0, 1'b0, 1'b1, 7'd1,   16'h00FF, 1, 1, 1'b0, 16'h0000};
        vecs[4]  = '{0, 1'b1, 1'b0, 7'd1,   16'h0000, 0, 1, 1'b0, 16'h00FF};
        vecs[5]  = '{0, 1'b1, 1'b1, 7'd3,   16'h0077, 0, 1, 1'b1, 16'h00FF};
        vecs[6]  = '{0, 1'b1, 1'b0, 7'd3,   16'h0000, 0, 1, 1'b0, 16'h0000};
        vecs[7]  = '{0, 1'b0, 1'b0, 7'd5,   16'h0033, 0, 1, 1'b1, 16'h0000};
        vecs[8]  = '{0, 1'b0, 1'b1, 7'd10,  16'h005A, 10, 1, 1'b0, 16'h0000};
        vecs[9]  = '{0, 1'b1, 1'b0, 7'd11,  16'h0000, 0, 1, 1'b0, 16'h0000};
        vecs[10] = '{0, 1'b1, 1'b0, 7'd10,  16'h0000, 0, 1, 1'b0, 16'h005A};
        vecs[11] = '{1, 1'b0, 1'b1, 7'd15,  16'hBEEF, 0, 4, 1'b0, 16'h0000};
        vecs[12] = '{1, 1'b1, 1'b0, 7'd15,  16'h0000, 0, 4, 1'b0, 16'hBEEF};
        vecs[13] = '{1, 1'b1, 1'b1, 7'd3,   16'h1111, 0, 4, 1'b1, 16'hBEEF};
        vecs[14] = '{1, 1'b1, 1'b0, 7'd3,   16'h0000, 0, 4, 1'b0, 16'h0000};

        rst0 = 1'b1; rst1 = 1'b1;
        set_in(0, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0);
        set_in(1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0);
        tick();
        tick();
        chk("rst_busy", busy0, 1'b1);
        chk("rst_ready", rdy0, 1'b0);
        chk("rst_err", err0, 1'b0);
        chk("rst_q", q0, 8'h00);

        // Interrupt the sweep part-way; it must start again from address 0.
        rst0 = 1'b0;
        repeat (50) tick();
        chk("clr_mid_busy", busy0, 1'b1);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        wait_clear(0, 128, "clr0");
        rst1 = 1'b0;
        wait_clear(1, 16, "clr1");

        for (int i = 0; i < 15; i++) begin
            do_req(vecs[i].which, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din,
                   vecs[i].hold, vecs[i].lat, vecs[i].err, vecs[i].q, $sformatf("v%0d", i));
        end

        // en dropped while BUSY: access still completes, DONE exits at once.
        set_in(1, 1'b1, 1'b0, 1'b1, 7'd7, 16'h1234);
        tick();
        set_in(1, 1'b0, 1'b1, 1'b0, 7'd2, 16'hFFFF);
        lat = 0;
        while (!rdy1 && lat < 40) begin
            tick();
            lat++;
        end
        chk("endrop_lat", lat, 4);
        tick();
        chk("endrop_exit", rdy1, 1'b0);
        do_req(1, 1'b1, 1'b0, 7'd7, 16'h0, 0, 4, 1'b0, 16'h1234, "endrop_rd");

        // Reset two edges after accepting a write: no completion, sweep wipes memory.
        do_req(1, 1'b0, 1'b1, 7'd9, 16'h00A5, 0, 4, 1'b0, 16'h1234, "mr_pre");
        set_in(1, 1'b1, 1'b0, 1'b1, 7'd9, 16'h0077);
        tick();
        saw = rdy1;
        tick();
        saw |= rdy1;
        set_in(1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0);
        rst1 = 1'b1;
        tick();
        saw |= rdy1;
        chk("mr_busy", busy1, 1'b1);
        chk("mr_q", q1, 16'h0000);
        rst1 = 1'b0;
        wait_clear(1, 16, "mr_clr");
        chk("mr_no_ready", saw, 1'b0);
        do_req(1, 1'b1, 1'b0, 7'd9, 16'h0, 0, 4, 1'b0, 16'h0000, "mr_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_memory.md
# param_memory

Parametrised single-port synchronous RAM with a four-phase `en`/`ready` handshake, configurable access latency, reset-time clear sweep and an error flag for illegal requests. It is the next-generation data memory for the 8-bit computer: the CPU control unit raises `en` with `read` or `write`, holds it until `ready`, then drops it. Width and depth are generic so the same block also serves as program memory and scratch RAM.

## Interface
- `DATA_W`, 8: data word width in bits.
- `ADDR_W`, 7: address width; depth = 2**ADDR_W words.
- `LATENCY`, 1: edges from request acceptance to access completion; legal range 1..15.
- `INIT_VALUE`, 0: value written to every word by the reset clear sweep.

- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: request; held high until `ready` is seen, then dropped.
- `read` input 1: read request qualifier.
- `write` input 1: write request qualifier.
- `address` input ADDR_W: word address, sampled at acceptance.
- `input_data` input DATA_W: write data, sampled at acceptance.
- `output_data` output DATA_W: last successfully read word.
- `ready` output 1: completion; high in DONE.
- `err` output 1: completed request was illegal (`read` and `write` both set, or both clear).
- `busy` output 1: high in CLEAR and BUSY.

## Operation
- States: CLEAR, IDLE, BUSY, DONE.
- CLEAR: entered at every edge with `rst`=1. `clr_addr` resets to 0; each edge with `rst`=0 writes INIT_VALUE to `mem[clr_addr]` and increments it; after the write to address 2**ADDR_W-1, go to IDLE. `en` is ignored in CLEAR.
- IDLE: at an edge with `en`=1, capture `address`, `input_data` and op, load `cnt`=LATENCY-1, go to BUSY. Op is READ (`read`=1, `write`=0), WRITE (`read`=0, `write`=1), or ILLEGAL (otherwise).
- BUSY: at an edge with `cnt`=0, perform the access and go to DONE; otherwise decrement `cnt`. WRITE stores the captured data. READ loads `output_data` from `mem[captured address]`. ILLEGAL makes no memory change, leaves `output_data` unchanged, and sets `err`.
- DONE: `ready`=1. At an edge with `en`=0, go to IDLE and clear `ready` and `err`. While `en` stays high, DONE holds and a new request is not accepted.
- Input changes after acceptance (`address`, `input_data`, `read`, `write`) have no effect on the pending access.
- Dropping `en` in BUSY does not cancel the access. DONE is still reached, and it exits on the first edge where `en`=0.

## Timing
- Reset values, registered and applied at the `rst` edge: `ready`=0, `err`=0, `busy`=1, `output_data`=0, state=CLEAR, `clr_addr`=0, `cnt`=0.
- Clear duration: 2**ADDR_W edges after the first edge with `rst`=0 (128 at default). `busy` falls with entry to IDLE.
- Access latency: request accepted at edge E0; access performed and `ready`=1 after edge E0+LATENCY. `output_data` is valid in the same cycle as `ready`.
- Minimum turnaround: `en` low for one edge in DONE, then high at the next edge, gives acceptance one edge after returning to IDLE.
- `rst` mid-operation:
  - any pending WRITE not yet performed is dropped;
  - state returns to CLEAR and the sweep restarts from address 0;
  - memory contents are overwritten by the sweep.
- `rst` during CLEAR restarts the sweep.
- `ready`, `err` and `busy` are pure state decodes from registers; no combinational path from inputs.
- Address wrap: none; `address` is exactly ADDR_W bits, so every value is in range.

## Structure
- Package `param_memory_pkg` holds:
  - the state enum (CLEAR, IDLE, BUSY, DONE);
  - the op enum (READ, WRITE, ILLEGAL);
  - the LATENCY range constants for elaboration-time assertion.
- Sub-module `mem_array`: the storage only. It has DATA_W×2**ADDR_W registers, one synchronous write port (`we`, `waddr`, `wdata`) and one synchronous read port. The top multiplexes the clear-sweep and request write paths into it.
- The top holds the FSM, the capture registers, `cnt`, `clr_addr` and the output registers.

## Test plan
- Reset and clear, defaults: hold `rst` for 2 edges, release → `busy`=1 and `ready`=0 for 128 edges, then `busy`=0; reading addresses 0, 64 and 127 returns 8'h00.
- Write/read, LATENCY=1: write 8'hFF to address 1 with `en` high for 3 edges → `ready` rises 1 edge after acceptance, `err`=0; drop `en` → `ready`=0 next edge; read address 1 → `output_data`=8'hFF with `ready`.
- LATENCY=4, DATA_W=16, ADDR_W=4: write 16'hBEEF to address 15 then read it back → `ready` appears exactly 4 edges after each acceptance; clear takes 16 edges; readback is 16'hBEEF.
- Illegal request: `en` with `read`=`write`=1 at address 3 → `ready`=1, `err`=1, `output_data` unchanged, `mem[3]` still 8'h00.
- Held `en`: keep `en` high 10 edges after `ready` → exactly one access and `ready` stays 1; a write issued this way stores once.
- Reset mid-write, LATENCY=4: assert `rst` 2 edges after accepting a write of 8'hA5 to address 9 → `ready` never rises; after the 128-edge clear, address 9 reads 8'h00.
